video_source_sel: RTL and testbench
===================================

Name: video_source_sel

Overview:
- Frame-synchronous selector that shares the single VGA output (hsync/vsync/rgb) among N_SRC 8bitworkshop game cores.
- Debounces the board keys and generates the pixel clock-enable for the cores.
- Switches cores only at a frame boundary.
- Holds every non-selected core in reset, and resets the newly selected core before showing it.

Parameters:
- SEL_W, 2, select width; N_SRC = 2**SEL_W sources.
- DIV, 2, pixel clock-enable period in clk cycles (≥2).
- DEB_CYCLES, 65536, cycles a key must be stable before it is accepted.
- RST_CYCLES, 16, cycles src_reset_n stays low on a switch/restart.
- TIMEOUT, 1048576, maximum cycles to wait for a frame boundary before forcing the switch.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- keys  in  4  raw asynchronous keys: [0] next, [1] prev, [2] restart, [3] reserved (ignored).
- src_hsync  in  N_SRC  hsync from each core.
- src_vsync  in  N_SRC  vsync from each core (active-high).
- src_rgb  in  3*N_SRC  rgb from each core; source i is at [3i+2:3i].
- pix_en  out  1  one-cycle clock-enable pulse every DIV cycles, shared by all cores.
- src_reset_n  out  N_SRC  per-core active-low reset.
- sel  out  SEL_W  currently displayed source.
- hsync  out  1  registered output sync.
- vsync  out  1  registered output sync.
- rgb  out  3  registered output colour.

Behaviour:
- Reset (reset=0), all outputs: pix_en=0, sel=0, src_reset_n=0 (all bits), hsync=0, vsync=0, rgb=0. Divider counter=0. Debounce state=0. FSM=RESET_SRC with counter=0.
- Divider: counts 0..DIV-1. pix_en=1 exactly in the cycle where count==DIV-1. Free-running in all FSM states.
- Keys: each key passes through a 2-flop synchronizer, then a debounce counter.
  - Counter clears whenever the synced value equals the stable value.
  - When the counter reaches DEB_CYCLES-1, the stable value flips.
  - A key event is the rising edge of the stable value: a single-cycle pulse.
- FSM states: RUN, WAIT_VS, RESET_SRC.
  - RUN:
    - next event alone → target=sel+1 (mod N_SRC, wraps N_SRC-1→0); go to WAIT_VS.
    - prev event alone → target=sel-1 (wraps 0→N_SRC-1); go to WAIT_VS.
    - restart event (next/prev not present) → target=sel; go to WAIT_VS.
    - next+prev in the same cycle → ignored.
    - Key events in WAIT_VS or RESET_SRC → dropped, not queued.
  - WAIT_VS:
    - Timeout counter increments every cycle.
    - On the rising edge of the selected src_vsync, or when the counter reaches TIMEOUT-1, whichever comes first: sel←target, counter←0, go to RESET_SRC.
  - RESET_SRC:
    - src_reset_n[sel]=0 for RST_CYCLES cycles.
    - Then src_reset_n[sel]=1 and go to RUN.
- src_reset_n[i]=0 for every i≠sel, in every state.
- Output mux (registered, 1 clk latency):
  - RUN and WAIT_VS: hsync/vsync/rgb ← src_*[sel] of the previous cycle.
  - RESET_SRC: hsync=0, vsync=0, rgb=0 (blanked, sync inactive).
- Reset deassertion: first RESET_SRC pass brings up source 0. Reset assertion mid-operation aborts any switch immediately and returns to the reset values.
- Vsync edge detection uses a registered copy of src_vsync[sel]. The registered copy is reloaded on the cycle sel changes, so a switch cannot create a false edge.

Test Plan:
- Power-up, using SEL_W=2, DIV=2, DEB_CYCLES=4, RST_CYCLES=8, TIMEOUT=100: release reset.
  - Required: src_reset_n=4'b0000 for 8 cycles, then 4'b0001.
  - Required: sel=0; rgb equals src_rgb[2:0] one cycle after input.
  - Required: pix_en pulses on every 2nd cycle.
- Debounce: keys[0] glitches high for 3 cycles → no switch. keys[0] held high for 10 cycles → a single WAIT_VS entry.
- Frame switch: next key, then src_vsync[0] rises 20 cycles later.
  - Required: sel=1 on the cycle after the edge; rgb/hsync/vsync=0 and src_reset_n=4'b0000 for 8 cycles.
  - Required: then src_reset_n=4'b0010, and outputs follow source 1.
- Wrap and timeout: sel=0, prev key, src_vsync held low → sel=3 after 100 cycles in WAIT_VS; src_reset_n ends at 4'b1000.
- Simultaneous and ignored events: next+prev in the same cycle → no state change. next pressed during RESET_SRC → dropped; sel unchanged after RUN is re-entered.
- Mid-operation reset: reset asserted during WAIT_VS → all outputs 0 immediately. After release, source 0 is restarted and target is discarded.

Source files
------------

// File: rtl/video_source_sel_if.sv
// Video bus between the source selector and the game cores / VGA pins.
// master = selector side, slave = cores plus display side.
interface video_source_sel_if #(
    parameter int SEL_W = 2
);
    localparam int N_SRC = 2**SEL_W;

    logic [N_SRC-1:0]   src_hsync;
    logic [N_SRC-1:0]   src_vsync;
    logic [3*N_SRC-1:0] src_rgb;
    logic               pix_en;
    logic [N_SRC-1:0]   src_reset_n;
    logic [SEL_W-1:0]   sel;
    logic               hsync;
    logic               vsync;
    logic [2:0]         rgb;

    modport master (
        input  src_hsync, src_vsync, src_rgb,
        output pix_en, src_reset_n, sel, hsync, vsync, rgb
    );

    modport slave (
        output src_hsync, src_vsync, src_rgb,
        input  pix_en, src_reset_n, sel, hsync, vsync, rgb
    );
endinterface

// File: rtl/video_source_sel.sv
// Frame-synchronous VGA source selector: debounced keys pick one of N_SRC cores,
// switching only at a vsync edge and restarting the new core before showing it.
module video_source_sel #(
    parameter int SEL_W      = 2,
    parameter int DIV        = 2,
    parameter int DEB_CYCLES = 65536,
    parameter int RST_CYCLES = 16,
    parameter int TIMEOUT    = 1048576
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         keys,
    video_source_sel_if.master vid
);
    localparam int N_SRC   = 2**SEL_W;
    localparam int DIV_W   = $clog2(DIV);
    localparam int DEB_W   = $clog2(DEB_CYCLES + 1);
    localparam int CNT_MAX = (TIMEOUT > RST_CYCLES) ? TIMEOUT : RST_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {RUN, WAIT_VS, RESET_SRC} state_t;

    // keys[3] is reserved
    logic unused_key3;
    assign unused_key3 = keys[3];

    // ---------------- pixel clock-enable ----------------
    logic [DIV_W-1:0] div_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                         div_q <= '0;
        else if (div_q == DIV_W'(DIV - 1))  div_q <= '0;
        else                                div_q <= div_q + 1'b1;
    end

    assign vid.pix_en = (div_q == DIV_W'(DIV - 1));

    // ---------------- key sync + debounce ----------------
    logic [2:0]            sync1_q, sync2_q, stable_q, ev_q;
    logic [2:0][DEB_W-1:0] deb_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            ev_q     <= '0;
            deb_q    <= '0;
        end else begin
            sync1_q <= keys[2:0];
            sync2_q <= sync1_q;
            for (int k = 0; k < 3; k++) begin
                ev_q[k] <= 1'b0;
                if (sync2_q[k] == stable_q[k]) begin
                    deb_q[k] <= '0;
                end else if (deb_q[k] == DEB_W'(DEB_CYCLES - 1)) begin
                    // accept the new level; only a 0->1 flip is an event
                    deb_q[k]    <= '0;
                    stable_q[k] <= sync2_q[k];
                    ev_q[k]     <= sync2_q[k];
                end else begin
                    deb_q[k] <= deb_q[k] + 1'b1;
                end
            end
        end
    end

    logic nxt_ev, prv_ev, rst_ev;
    assign nxt_ev = ev_q[0];
    assign prv_ev = ev_q[1];
    assign rst_ev = ev_q[2];

    // ---------------- source select FSM + output mux ----------------
    state_t               state_q;
    logic [SEL_W-1:0]     sel_q, tgt_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [N_SRC-1:0]     srn_q;
    logic                 vs_prev_q;
    logic                 hs_q, vs_q;
    logic [2:0]           rgb_q;
    logic [N_SRC-1:0][2:0] rgb_arr;
    logic                 vs_cur, vs_rise;

    assign rgb_arr = vid.src_rgb;
    assign vs_cur  = vid.src_vsync[sel_q];
    assign vs_rise = vs_cur & ~vs_prev_q;

    // Outputs blank on exactly the cycles the shown core is held in reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= RESET_SRC;
            sel_q     <= '0;
            tgt_q     <= '0;
            cnt_q     <= '0;
            srn_q     <= '0;
            vs_prev_q <= 1'b0;
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            rgb_q     <= '0;
        end else begin
            vs_prev_q <= vs_cur;
            hs_q      <= vid.src_hsync[sel_q];
            vs_q      <= vs_cur;
            rgb_q     <= rgb_arr[sel_q];
            case (state_q)
                RUN: begin
                    cnt_q <= '0;
                    if (nxt_ev && !prv_ev) begin
                        tgt_q   <= sel_q + 1'b1;
                        state_q <= WAIT_VS;
                    end else if (prv_ev && !nxt_ev) begin
                        tgt_q   <= sel_q - 1'b1;
                        state_q <= WAIT_VS;
                    end else if (rst_ev && !nxt_ev && !prv_ev) begin
                        tgt_q   <= sel_q;
                        state_q <= WAIT_VS;
                    end
                end
                WAIT_VS: begin
                    if (vs_rise || cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        sel_q     <= tgt_q;
                        cnt_q     <= '0;
                        state_q   <= RESET_SRC;
                        srn_q     <= '0;
                        // reload from the new source so the switch itself is no edge
                        vs_prev_q <= vid.src_vsync[tgt_q];
                        hs_q      <= 1'b0;
                        vs_q      <= 1'b0;
                        rgb_q     <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESET_SRC: begin
                    if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                        cnt_q   <= '0;
                        state_q <= RUN;
                        srn_q   <= N_SRC'(1) << sel_q;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        hs_q  <= 1'b0;
                        vs_q  <= 1'b0;
                        rgb_q <= '0;
                    end
                end
                default: begin
                    state_q <= RESET_SRC;
                    cnt_q   <= '0;
                    srn_q   <= '0;
                end
            endcase
        end
    end

    assign vid.sel         = sel_q;
    assign vid.src_reset_n = srn_q;
    assign vid.hsync       = hs_q;
    assign vid.vsync       = vs_q;
    assign vid.rgb         = rgb_q;

endmodule

// File: tb/tb_video_source_sel.sv
// Directed bench for video_source_sel: mux vector table plus hand-written
// key / frame-switch / timeout / reset sequences.
module tb_video_source_sel;
    logic       clk;
    logic       reset;
    logic [3:0] keys;

    int checks = 0;
    int errors = 0;

    video_source_sel_if #(.SEL_W(2)) vif();

    video_source_sel #(
        .SEL_W(2), .DIV(2), .DEB_CYCLES(4), .RST_CYCLES(8), .TIMEOUT(100)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .keys  (keys),
        .vid   (vif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [3:0]  h;
        logic [3:0]  v;
        logic [11:0] rgb;
        logic [4:0]  e0;   // {hsync,vsync,rgb} expected with sel=0
        logic [4:0]  e1;   // same with sel=1
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] outs();
        return {27'd0, vif.hsync, vif.vsync, vif.rgb};
    endfunction

    task automatic zero_src();
        vif.src_hsync = '0;
        vif.src_vsync = '0;
        vif.src_rgb   = '0;
    endtask

    initial begin
        int n;
        int m;
        tbl[0] = '{h:4'b0001, v:4'b0000, rgb:12'h005, e0:5'b10101, e1:5'b00000};
        tbl[1] = '{h:4'b0010, v:4'b0001, rgb:12'h038, e0:5'b01000, e1:5'b10111};
        tbl[2] = '{h:4'b1100, v:4'b1110, rgb:12'hFC6, e0:5'b00110, e1:5'b01000};
        tbl[3] = '{h:4'b0011, v:4'b0011, rgb:12'h0FF, e0:5'b11111, e1:5'b11111};
        tbl[4] = '{h:4'b1110, v:4'b0000, rgb:12'hE2B, e0:5'b00011, e1:5'b10101};

        reset = 1'b0;
        keys  = 4'b0000;
        zero_src();
        cyc(3);
        chk("rst_pix_en", {31'd0, vif.pix_en}, 0);
        chk("rst_sel", {30'd0, vif.sel}, 0);
        chk("rst_srn", {28'd0, vif.src_reset_n}, 0);
        chk("rst_outs", outs(), 0);

        // power-up: source 0 held in reset for 8 cycles, pix_en every 2nd cycle
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("pwr_srn_low", {28'd0, vif.src_reset_n}, 0);
            chk("pwr_pix_en", {31'd0, vif.pix_en}, k % 2);
            cyc(1);
        end
        chk("pwr_srn_up", {28'd0, vif.src_reset_n}, 4'b0001);
        chk("pwr_sel", {30'd0, vif.sel}, 0);
        chk("pwr_pix_en8", {31'd0, vif.pix_en}, 0);

        for (int i = 0; i < 5; i++) begin
            vif.src_hsync = tbl[i].h;
            vif.src_vsync = tbl[i].v;
            vif.src_rgb   = tbl[i].rgb;
            cyc(1);
            chk($sformatf("mux0_v%0d", i), outs(), {27'd0, tbl[i].e0});
        end
        zero_src();
        cyc(2);

        // debounce: 3-cycle glitch must not arm a switch
        keys = 4'b0001;
        cyc(3);
        keys = 4'b0000;
        cyc(10);
        vif.src_vsync = 4'b0001;
        cyc(2);
        chk("glitch_sel", {30'd0, vif.sel}, 0);
        chk("glitch_srn", {28'd0, vif.src_reset_n}, 4'b0001);
        vif.src_vsync = 4'b0000;
        cyc(3);

        // held next key, vsync of source 0 rises 20 cycles later
        keys = 4'b0001;
        cyc(10);
        keys = 4'b0000;
        cyc(10);
        chk("wait_sel", {30'd0, vif.sel}, 0);
        vif.src_vsync = 4'b0011;
        vif.src_hsync = 4'b1111;
        vif.src_rgb   = 12'hFFF;
        cyc(1);
        chk("sw_sel", {30'd0, vif.sel}, 1);
        for (int k = 0; k < 8; k++) begin
            chk("sw_srn_low", {28'd0, vif.src_reset_n}, 0);
            chk("sw_blank", outs(), 0);
            cyc(1);
        end
        chk("sw_srn_up", {28'd0, vif.src_reset_n}, 4'b0010);
        chk("sw_outs_src1", outs(), 5'b11111);
        for (int i = 0; i < 5; i++) begin
            vif.src_hsync = tbl[i].h;
            vif.src_vsync = tbl[i].v;
            vif.src_rgb   = tbl[i].rgb;
            cyc(1);
            chk($sformatf("mux1_v%0d", i), outs(), {27'd0, tbl[i].e1});
        end
        zero_src();
        cyc(2);
        // one held press must have produced only one switch
        vif.src_vsync = 4'b0010;
        cyc(2);
        chk("single_sel", {30'd0, vif.sel}, 1);
        chk("single_srn", {28'd0, vif.src_reset_n}, 4'b0010);
        vif.src_vsync = 4'b0000;
        cyc(3);

        // prev from 1 via vsync edge -> 0
        keys = 4'b0010;
        cyc(8);
        keys = 4'b0000;
        cyc(10);
        vif.src_vsync = 4'b0010;
        cyc(1);
        chk("prev_sel", {30'd0, vif.sel}, 0);
        vif.src_vsync = 4'b0000;
        cyc(8);
        chk("prev_srn", {28'd0, vif.src_reset_n}, 4'b0001);
        cyc(5);

        // prev from 0 wraps to 3 via timeout, vsync held low
        keys = 4'b0010;
        n = 0;
        while (vif.sel == 2'd0 && n < 200) begin
            cyc(1);
            n++;
            if (n == 8) keys = 4'b0000;
        end
        keys = 4'b0000;
        chk("wrap_sel", {30'd0, vif.sel}, 3);
        chk("timeout_window", {31'd0, (n >= 101 && n <= 108)}, 1);
        m = 0;
        while (vif.src_reset_n == 4'b0000 && m < 20) begin
            cyc(1);
            m++;
        end
        chk("wrap_srn_cycles", m, 8);
        chk("wrap_srn", {28'd0, vif.src_reset_n}, 4'b1000);
        cyc(5);

        // next+prev together: ignored
        keys = 4'b0011;
        cyc(8);
        keys = 4'b0000;
        cyc(10);
        vif.src_vsync = 4'b1000;
        cyc(2);
        chk("both_sel", {30'd0, vif.sel}, 3);
        chk("both_srn", {28'd0, vif.src_reset_n}, 4'b1000);
        vif.src_vsync = 4'b0000;
        cyc(3);

        // restart source 3; a next press during RESET_SRC is dropped
        keys = 4'b0100;
        cyc(8);
        keys = 4'b0000;
        cyc(5);
        vif.src_vsync = 4'b1000;
        cyc(1);
        chk("restart_sel", {30'd0, vif.sel}, 3);
        chk("restart_srn", {28'd0, vif.src_reset_n}, 0);
        keys = 4'b0001;
        cyc(6);
        keys = 4'b0000;
        cyc(2);
        chk("restart_srn_up", {28'd0, vif.src_reset_n}, 4'b1000);
        vif.src_vsync = 4'b0000;
        cyc(10);
        vif.src_vsync = 4'b1001;
        cyc(2);
        chk("dropped_sel", {30'd0, vif.sel}, 3);
        vif.src_vsync = 4'b0000;
        cyc(3);

        // reset during WAIT_VS (target 2) aborts the switch
        vif.src_hsync = 4'b1111;
        vif.src_rgb   = 12'hFFF;
        keys = 4'b0010;
        cyc(8);
        keys = 4'b0000;
        cyc(5);
        chk("wait_outs_src3", outs(), 5'b10111);
        #2 reset = 1'b0;
        #1;
        chk("midrst_sel", {30'd0, vif.sel}, 0);
        chk("midrst_srn", {28'd0, vif.src_reset_n}, 0);
        chk("midrst_outs", outs(), 0);
        chk("midrst_pix_en", {31'd0, vif.pix_en}, 0);
        @(negedge clk);
        reset = 1'b1;
        cyc(8);
        chk("rerun_sel", {30'd0, vif.sel}, 0);
        chk("rerun_srn", {28'd0, vif.src_reset_n}, 4'b0001);
        vif.src_vsync = 4'b0101;
        cyc(2);
        chk("discard_sel", {30'd0, vif.sel}, 0);
        chk("discard_srn", {28'd0, vif.src_reset_n}, 4'b0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
